// File: rtl/cursor_controller.sv
// Push-button front end for life_logic: 2-flop sync, per-button debounce,
// auto-repeating wrap-around cursor steps per axis, and a one-cycle centre-button click.
module cursor_controller #(
  parameter int BOARD_W         = 512,
  parameter int BOARD_H         = 512,
  parameter int POS_W           = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             btnu_in,
  input  logic             btnd_in,
  input  logic             btnl_in,
  input  logic             btnr_in,
  input  logic             btnc_in,
  output logic [POS_W-1:0] cursor_x_out,
  output logic [POS_W-1:0] cursor_y_out,
  output logic             click_out,
  output logic             moving_out
);

  localparam int NB      = 5;
  localparam int BU      = 0;
  localparam int BD      = 1;
  localparam int BL      = 2;
  localparam int BR      = 3;
  localparam int BC      = 4;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [POS_W-1:0] X_MAX      = POS_W'(BOARD_W - 1);
  localparam logic [POS_W-1:0] Y_MAX      = POS_W'(BOARD_H - 1);
  localparam logic [POS_W-1:0] X_MID      = POS_W'(BOARD_W / 2);
  localparam logic [POS_W-1:0] Y_MID      = POS_W'(BOARD_H / 2);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DELAY = 2'd1, ST_REPEAT = 2'd2} dir_state_t;

  logic [NB-1:0]    btn_raw, sync_q1, sync_q2, deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [NB];
  logic [DEB_W-1:0] deb_cnt_d [NB];
  logic             btnc_seen_q;

  // Per axis: index 0 = x, 1 = y. Direction is {positive, negative}.
  dir_state_t       st_q  [2];
  dir_state_t       st_d  [2];
  logic [1:0]       dir_q [2];
  logic [1:0]       dir_d [2];
  logic [RPT_W-1:0] rpt_q [2];
  logic [RPT_W-1:0] rpt_d [2];
  logic [1:0]       step_en;
  logic [POS_W-1:0] x_nxt, y_nxt;

  assign btn_raw = {btnc_in, btnr_in, btnl_in, btnd_in, btnu_in};

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      deb_d[b]     = deb_q[b];
      deb_cnt_d[b] = '0;
      if (sync_q2[b] != deb_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) deb_d[b] = ~deb_q[b];
        else                          deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      deb_q   <= '0;
      for (int b = 0; b < NB; b++) deb_cnt_q[b] <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      deb_q   <= deb_d;
      for (int b = 0; b < NB; b++) deb_cnt_q[b] <= deb_cnt_d[b];
    end
  end

  // Direction follows the level being debounced this cycle so the first step lands with it.
  always_comb begin
    dir_d[0] = {deb_d[BR] & ~deb_d[BL], deb_d[BL] & ~deb_d[BR]};
    dir_d[1] = {deb_d[BD] & ~deb_d[BU], deb_d[BU] & ~deb_d[BD]};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int a = 0; a < 2; a++) begin
        st_q[a]  <= ST_IDLE;
        dir_q[a] <= 2'b00;
        rpt_q[a] <= '0;
      end
    end else begin
      for (int a = 0; a < 2; a++) begin
        st_q[a]  <= st_d[a];
        dir_q[a] <= dir_d[a];
        rpt_q[a] <= rpt_d[a];
      end
    end
  end

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      st_d[a] = st_q[a];
      if (dir_d[a] == 2'b00)            st_d[a] = ST_IDLE;
      else if (dir_d[a] != dir_q[a])    st_d[a] = ST_DELAY;
      else if (st_q[a] == ST_DELAY && rpt_q[a] <= RPT_ONE) st_d[a] = ST_REPEAT;
    end
  end

  // A new or sign-flipped direction steps at once; otherwise step when the countdown expires.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      step_en[a] = 1'b0;
      rpt_d[a]   = rpt_q[a];
      if (dir_d[a] == 2'b00) begin
        rpt_d[a] = '0;
      end else if (dir_d[a] != dir_q[a]) begin
        step_en[a] = 1'b1;
        rpt_d[a]   = RPT_DELAY;
      end else if (st_q[a] != ST_IDLE) begin
        if (rpt_q[a] <= RPT_ONE) begin
          step_en[a] = 1'b1;
          rpt_d[a]   = RPT_PERIOD;
        end else begin
          rpt_d[a] = rpt_q[a] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    x_nxt = cursor_x_out;
    y_nxt = cursor_y_out;
    if (step_en[0]) begin
      if (dir_d[0][1]) x_nxt = (cursor_x_out == X_MAX) ? '0 : cursor_x_out + 1'b1;
      else             x_nxt = (cursor_x_out == '0) ? X_MAX : cursor_x_out - 1'b1;
    end
    if (step_en[1]) begin
      if (dir_d[1][1]) y_nxt = (cursor_y_out == Y_MAX) ? '0 : cursor_y_out + 1'b1;
      else             y_nxt = (cursor_y_out == '0) ? Y_MAX : cursor_y_out - 1'b1;
    end
  end

  // Click leaves one cycle after the debounced rise, alongside the pre-step position.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cursor_x_out <= X_MID;
      cursor_y_out <= Y_MID;
      click_out    <= 1'b0;
      btnc_seen_q  <= 1'b0;
      moving_out   <= 1'b0;
    end else begin
      cursor_x_out <= x_nxt;
      cursor_y_out <= y_nxt;
      click_out    <= deb_q[BC] & ~btnc_seen_q;
      btnc_seen_q  <= deb_q[BC];
      moving_out   <= |deb_q[BR:BU];
    end
  end

endmodule
